// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> FETCH -> EXEC loop with
// wait-state tolerant memory handshake and decoder-driven PC update.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] iAddr,
   output logic        iReq,
   input  logic [15:0] iData,
   input  logic        iReady,
   output logic [15:0] instruction,
   output logic        instrValid,
   input  logic [1:0]  nextPCSel,
   input  logic [15:0] instrData,
   input  logic        stall,
   output logic [15:0] pc,
   output logic [15:0] retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        ireq_q, ireq_d;
   logic [15:0] retired_q, retired_d;
   logic [15:0] pc_next;

   always_comb begin
      pc_next = pc_q + 16'd1;
      unique case (nextPCSel)
         2'b01:   pc_next = pc_q + instrData;
         2'b10:   pc_next = instrData;
         default: pc_next = pc_q + 16'd1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      ireq_d    = ireq_q;
      retired_d = retired_q;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
            ireq_d  = 1'b1;
            valid_d = 1'b0;
         end
         FETCH: begin
            if (iReady) begin
               state_d = EXEC;
               instr_d = iData;
               valid_d = 1'b1;
               ireq_d  = 1'b0;
            end
         end
         EXEC: begin
            // decoder inputs only matter on the retiring cycle
            if (!stall) begin
               state_d   = FETCH;
               pc_d      = pc_next;
               valid_d   = 1'b0;
               ireq_d    = 1'b1;
               retired_d = retired_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            ireq_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 16'h0000;
         valid_q   <= 1'b0;
         ireq_q    <= 1'b0;
         retired_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         ireq_q    <= ireq_d;
         retired_q <= retired_d;
      end
   end

   assign iAddr       = pc_q;
   assign iReq        = ireq_q;
   assign instruction = instr_q;
   assign instrValid  = valid_q;
   assign pc          = pc_q;
   assign retired     = retired_q;

endmodule
